// File: rtl/imm_ctrl_if.sv
// Handshake and result bundle between the instruction register side and the
// immediate-decode controller. The slave modport is the controller's view.
interface imm_ctrl_if;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        imm_done;
   logic        flush;
   logic [19:0] imm;
   logic [1:0]  sz_ex_mode;
   logic        sz_ex_sel;
   logic        has_imm;
   logic        illegal;
   logic        imm_valid;

   modport slave (
      input  instr,
      input  instr_valid,
      input  imm_done,
      input  flush,
      output instr_ready,
      output imm,
      output sz_ex_mode,
      output sz_ex_sel,
      output has_imm,
      output illegal,
      output imm_valid
   );

   modport master (
      output instr,
      output instr_valid,
      output imm_done,
      output flush,
      input  instr_ready,
      input  imm,
      input  sz_ex_mode,
      input  sz_ex_sel,
      input  has_imm,
      input  illegal,
      input  imm_valid
   );
endinterface

// File: rtl/imm_ctrl.sv
// Immediate-decode controller: latches an instruction, packs its immediate for
// the sign/zero extender and holds the result until the main FSM releases it.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | ready for a new instruction; outputs keep last decode
//   S_DECODE | instr_q latched; decode results registered this cycle
//   S_HOLD   | outputs frozen and imm_valid high until imm_done
module imm_ctrl (
   input  logic     clk,
   input  logic     rst_n,
   imm_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [1:0] MODE_STD    = 2'b00;
   localparam logic [1:0] MODE_BRANCH = 2'b01;
   localparam logic [1:0] MODE_UTYPE  = 2'b10;
   localparam logic [1:0] MODE_JAL    = 2'b11;

   state_t      state_q;
   logic [31:0] instr_q;
   logic [19:0] imm_q,        imm_d;
   logic [1:0]  sz_ex_mode_q, sz_ex_mode_d;
   logic        sz_ex_sel_q,  sz_ex_sel_d;
   logic        has_imm_q,    has_imm_d;
   logic        illegal_q,    illegal_d;
   logic        imm_valid_q;

   // funct3[1:0] never influences immediate packing
   logic unused_funct3;
   assign unused_funct3 = ^instr_q[13:12];

   always_comb begin
      imm_d        = '0;
      sz_ex_mode_d = MODE_STD;
      sz_ex_sel_d  = 1'b0;
      has_imm_d    = 1'b0;
      illegal_d    = 1'b0;
      case (instr_q[6:0])
         OP_LOAD, OP_OPIMM, OP_JALR: begin
            imm_d       = {8'b0, instr_q[31:20]};
            sz_ex_sel_d = 1'b1;
            has_imm_d   = 1'b1;
         end
         OP_STORE: begin
            imm_d       = {8'b0, instr_q[31:25], instr_q[11:7]};
            sz_ex_sel_d = 1'b1;
            has_imm_d   = 1'b1;
         end
         OP_BRANCH: begin
            imm_d        = {8'b0, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
            sz_ex_mode_d = MODE_BRANCH;
            sz_ex_sel_d  = 1'b1;
            has_imm_d    = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm_d        = instr_q[31:12];
            sz_ex_mode_d = MODE_UTYPE;
            has_imm_d    = 1'b1;
         end
         OP_JAL: begin
            imm_d        = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};
            sz_ex_mode_d = MODE_JAL;
            sz_ex_sel_d  = 1'b1;
            has_imm_d    = 1'b1;
         end
         OP_SYSTEM: begin
            // CSR*I forms carry a 5-bit zero-extended uimm in the rs1 field
            if (instr_q[14]) begin
               imm_d     = {15'b0, instr_q[19:15]};
               has_imm_d = 1'b1;
            end
         end
         OP_OP, OP_FENCE: begin
            has_imm_d = 1'b0;
         end
         default: begin
            illegal_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         instr_q      <= '0;
         imm_q        <= '0;
         sz_ex_mode_q <= MODE_STD;
         sz_ex_sel_q  <= 1'b0;
         has_imm_q    <= 1'b0;
         illegal_q    <= 1'b0;
         imm_valid_q  <= 1'b0;
      end else if (bus.flush) begin
         state_q     <= S_IDLE;
         imm_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  instr_q <= bus.instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               imm_q        <= imm_d;
               sz_ex_mode_q <= sz_ex_mode_d;
               sz_ex_sel_q  <= sz_ex_sel_d;
               has_imm_q    <= has_imm_d;
               illegal_q    <= illegal_d;
               imm_valid_q  <= 1'b1;
               state_q      <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.imm_done) begin
                  imm_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               imm_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.imm         = imm_q;
   assign bus.sz_ex_mode  = sz_ex_mode_q;
   assign bus.sz_ex_sel   = sz_ex_sel_q;
   assign bus.has_imm     = has_imm_q;
   assign bus.illegal     = illegal_q;
   assign bus.imm_valid   = imm_valid_q;

endmodule

// File: tb/tb_imm_ctrl.sv
// Directed bench for imm_ctrl: hand-decoded instruction vectors, handshake
// timing, flush/done boundaries and asynchronous reset.
module tb_imm_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   imm_ctrl_if bus ();

   imm_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_imm"},   bus.imm,         0);
      chk({tag, "_mode"},  bus.sz_ex_mode,  0);
      chk({tag, "_sel"},   bus.sz_ex_sel,   0);
      chk({tag, "_has"},   bus.has_imm,     0);
      chk({tag, "_ill"},   bus.illegal,     0);
      chk({tag, "_valid"}, bus.imm_valid,   0);
      chk({tag, "_ready"}, bus.instr_ready, 1);
   endtask

   task automatic run_instr(input string tag, input logic [31:0] ins,
                            input logic [19:0] e_imm, input logic [1:0] e_mode,
                            input logic e_sel, input logic e_has, input logic e_ill,
                            input int hold_cyc);
      chk({tag, "_ready_idle"}, bus.instr_ready, 1);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      chk({tag, "_valid_e0"}, bus.imm_valid,   0);
      chk({tag, "_ready_e0"}, bus.instr_ready, 0);
      step();
      chk({tag, "_valid_e1"}, bus.imm_valid,  1);
      chk({tag, "_imm"},      bus.imm,        e_imm);
      chk({tag, "_mode"},     bus.sz_ex_mode, e_mode);
      chk({tag, "_sel"},      bus.sz_ex_sel,  e_sel);
      chk({tag, "_has"},      bus.has_imm,    e_has);
      chk({tag, "_ill"},      bus.illegal,    e_ill);
      for (int i = 0; i < hold_cyc; i++) begin
         step();
         chk({tag, "_hold_valid"}, bus.imm_valid,  1);
         chk({tag, "_hold_imm"},   bus.imm,        e_imm);
         chk({tag, "_hold_mode"},  bus.sz_ex_mode, e_mode);
         chk({tag, "_hold_ready"}, bus.instr_ready, 0);
      end
      bus.imm_done = 1'b1;
      step();
      bus.imm_done = 1'b0;
      chk({tag, "_done_valid"}, bus.imm_valid,   0);
      chk({tag, "_done_ready"}, bus.instr_ready, 1);
      chk({tag, "_keep_imm"},   bus.imm,         e_imm);
      chk({tag, "_keep_has"},   bus.has_imm,     e_has);
   endtask

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      rst_n           = 1'b0;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.imm_done    = 1'b0;
      bus.flush       = 1'b0;
      step();
      step();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      step();
      chk("rst_rel_ready", bus.instr_ready, 1);

      //        tag       instr         imm       mode  sel   has   ill  hold
      run_instr("addi",   32'hFFF00093, 20'h00FFF, 2'b00, 1'b1, 1'b1, 1'b0, 1);
      run_instr("beq",    32'hFE000EE3, 20'h00FFE, 2'b01, 1'b1, 1'b1, 1'b0, 0);
      run_instr("sw",     32'hFE112C23, 20'h00FF8, 2'b00, 1'b1, 1'b1, 1'b0, 0);
      run_instr("lui",    32'h123452B7, 20'h12345, 2'b10, 1'b0, 1'b1, 1'b0, 10);
      run_instr("auipc",  32'h00001097, 20'h00001, 2'b10, 1'b0, 1'b1, 1'b0, 0);
      run_instr("jal",    32'h001000EF, 20'h00400, 2'b11, 1'b1, 1'b1, 1'b0, 0);
      run_instr("csrrwi", 32'h3002D0F3, 20'h00005, 2'b00, 1'b0, 1'b1, 1'b0, 0);
      run_instr("add",    32'h002081B3, 20'h00000, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      run_instr("ecall",  32'h00000073, 20'h00000, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      run_instr("bad",    32'h0000007F, 20'h00000, 2'b00, 1'b0, 1'b0, 1'b1, 0);
      run_instr("addi2",  32'hFFF00093, 20'h00FFF, 2'b00, 1'b1, 1'b1, 1'b0, 0);

      // flush while holding a result
      bus.instr = 32'h123452B7; bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      step();
      chk("fh_valid_pre", bus.imm_valid, 1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("fh_valid", bus.imm_valid,   0);
      chk("fh_ready", bus.instr_ready, 1);
      chk("fh_imm",   bus.imm,         20'h12345);

      // flush together with a valid offer in IDLE
      bus.instr = 32'h001000EF; bus.instr_valid = 1'b1; bus.flush = 1'b1;
      step();
      bus.instr_valid = 1'b0; bus.flush = 1'b0;
      chk("fi_ready", bus.instr_ready, 1);
      chk("fi_valid", bus.imm_valid,   0);
      step();
      chk("fi_ready2", bus.instr_ready, 1);
      chk("fi_imm",    bus.imm,         20'h12345);

      // flush in DECODE drops the result
      bus.instr = 32'h001000EF; bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("fd_valid", bus.imm_valid,   0);
      chk("fd_ready", bus.instr_ready, 1);
      chk("fd_imm",   bus.imm,         20'h12345);
      chk("fd_mode",  bus.sz_ex_mode,  2'b10);
      step();
      chk("fd_valid2", bus.imm_valid, 0);

      // imm_done ignored in IDLE and DECODE
      bus.imm_done = 1'b1;
      step();
      chk("di_ready", bus.instr_ready, 1);
      bus.instr = 32'h001000EF; bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      chk("dd_ready", bus.instr_ready, 0);
      step();
      chk("dd_valid", bus.imm_valid, 1);
      chk("dd_imm",   bus.imm,       20'h00400);
      step();
      bus.imm_done = 1'b0;
      chk("dd_rel_valid", bus.imm_valid,   0);
      chk("dd_rel_ready", bus.instr_ready, 1);

      // asynchronous reset in the middle of HOLD
      bus.instr = 32'hFFF00093; bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
      step();
      chk("ar_valid_pre", bus.imm_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("ar");
      #1;
      rst_n = 1'b1;
      step();
      chk("ar_rel_ready", bus.instr_ready, 1);
      chk("ar_rel_valid", bus.imm_valid,   0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
